alu_op_queue: RTL and testbench
===============================

Name: alu_op_queue

Overview:
- Upstream issue stage for the ALU control decoder.
- Accepts operations {3-bit opcode, operand A, operand B} from the fetch/decode front end over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the head entry to the decoder and datapath as OP/A/B with a valid/ready handshake.
- Filters opcode 3'b111, which the decoder does not define, so that an undefined opcode never reaches it.

Parameters:
- WIDTH, 8, operand width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  upstream offers an operation.
- IN_READY  output  1  queue can accept an operation.
- IN_OP  input  3  opcode.
- IN_A  input  WIDTH  operand A.
- IN_B  input  WIDTH  operand B.
- FLUSH  input  1  synchronous discard of all queued entries.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  ALU consumes the head this cycle.
- OP  output  3  head opcode, to the control decoder.
- A  output  WIDTH  head operand A.
- B  output  WIDTH  head operand B.
- COUNT  output  CW  number of stored entries, 0..DEPTH.
- ILLEGAL  output  1  sticky flag: an opcode 3'b111 was dropped.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - Write pointer, read pointer and COUNT go to 0; ILLEGAL goes to 0.
  - OUT_VALID=0, IN_READY=1 in the following cycle.
  - RESET has priority over all other inputs.
  - RESET mid-stream discards all entries; no partial pop is observable.
- IN_READY = (COUNT != DEPTH). Combinational from state only; it never depends on IN_VALID or OUT_READY.
- Push = IN_VALID & IN_READY & (IN_OP != 3'b111). The entry is written at wptr, and wptr increments modulo DEPTH.
- Illegal op: IN_VALID & IN_READY & IN_OP==3'b111.
  - The handshake completes (the upstream is released), but nothing is stored.
  - ILLEGAL is set to 1 on the next edge and stays set until RESET or FLUSH.
- Pop = OUT_VALID & OUT_READY. rptr increments modulo DEPTH.
- OUT_VALID = (COUNT != 0).
- OP/A/B are driven from the storage at rptr (registered storage, combinational read mux).
- When COUNT==0, OP=3'b000 and A=B=0, never stale or X values. This keeps the decoder outputs deterministic while idle.
- Latency:
  - An op pushed at edge N is visible on OP/A/B with OUT_VALID=1 in the cycle after edge N.
  - There is no combinational bypass from IN_* to OP/A/B.
- Simultaneous push and pop (0<COUNT<DEPTH): both pointers advance and COUNT is unchanged.
- Simultaneous push and pop when COUNT==DEPTH: cannot occur (IN_READY=0). A pop when full frees one slot, and IN_READY=1 the next cycle.
- Pop when empty: impossible (OUT_VALID=0). OUT_READY is ignored.
- COUNT update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
  - Illegal ops do not change COUNT.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are decided from COUNT, not from pointer comparison.
- FLUSH=1 at an edge:
  - Pointers, COUNT and ILLEGAL all go to 0.
  - Any push or pop in that same cycle is ignored: a handshake that appears complete in the FLUSH cycle is discarded.
  - FLUSH has lower priority than RESET.
- OP/A/B/OUT_VALID must hold stable while OUT_VALID=1 and OUT_READY=0.
- Storage contents are not reset. Only pointers, COUNT and flags are reset.

Test Plan:
1. Reset then idle → OUT_VALID=0, IN_READY=1, COUNT=0, OP=3'b000, A=B=0, ILLEGAL=0.
2. Push (OP=3'b001, A=8'h05, B=8'h03) with OUT_READY=0 → the next cycle shows OUT_VALID=1, OP=3'b001, A=8'h05, B=8'h03, COUNT=1; all three hold until OUT_READY=1, then OUT_VALID=0 the following cycle.
3. Push ops 0,2,4,5,6 back-to-back with OUT_READY=0, DEPTH=4:
   - Four entries are accepted; IN_READY=0 once COUNT=4, and op 6 stalls.
   - Assert OUT_READY: ops pop in order 0,2,4,5, and op 6 is accepted one cycle after the first pop.
   - Pointers wrap correctly.
4. Steady streaming, IN_VALID=OUT_READY=1 for 20 cycles with incrementing A → COUNT stays at 1 after fill; outputs appear in order with no drops or duplicates.
5. Push OP=3'b111 (A=8'hFF) between two legal ops → IN_READY=1 and the handshake completes; ILLEGAL=1 the next cycle; COUNT increases by only the 2 legal ops; 3'b111 never appears on OP.
6. COUNT=3 with ILLEGAL=1; assert FLUSH together with IN_VALID and OUT_READY → the next cycle shows COUNT=0, OUT_VALID=0, ILLEGAL=0, and nothing from that cycle is stored. Repeat with RESET=1 mid-stream → same empty state.

Source files
------------

// File: rtl/alu_op_queue_if.sv
// Handshake bundle between the fetch/decode front end, the op queue and the ALU decoder.
// The slave view is the queue itself; the master view is whoever drives and consumes it.
interface alu_op_queue_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_OP;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             FLUSH;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [CW-1:0]    COUNT;
    logic             ILLEGAL;

    modport slave (
        input  IN_VALID, IN_OP, IN_A, IN_B, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OP, A, B, COUNT, ILLEGAL
    );

    modport master (
        output IN_VALID, IN_OP, IN_A, IN_B, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OP, A, B, COUNT, ILLEGAL
    );
endinterface

// File: rtl/alu_op_queue.sv
// Issue-stage FIFO in front of the ALU control decoder; drops undefined opcode 3'b111
// and presents the head entry with a zeroed, deterministic bus while empty.
module alu_op_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          CLK,
    input logic          RESET,
    alu_op_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [2:0]       op_mem [DEPTH];
    logic [WIDTH-1:0] a_mem  [DEPTH];
    logic [WIDTH-1:0] b_mem  [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          illegal;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic drop;
    logic pop;

    always_comb begin
        full   = (count == CW'(DEPTH));
        empty  = (count == '0);
        accept = bus.IN_VALID && !full;
        push   = accept && (bus.IN_OP != 3'b111);
        drop   = accept && (bus.IN_OP == 3'b111);
        pop    = !empty && bus.OUT_READY;
    end

    // Full/empty come from count, so pointers are free to wrap naturally.
    always_ff @(posedge CLK) begin
        if (RESET || bus.FLUSH) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            illegal <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) illegal <= 1'b1;
        end
    end

    // Storage is never reset; only the pointers decide what is live.
    always_ff @(posedge CLK) begin
        if (push && !RESET && !bus.FLUSH) begin
            op_mem[wptr] <= bus.IN_OP;
            a_mem[wptr]  <= bus.IN_A;
            b_mem[wptr]  <= bus.IN_B;
        end
    end

    assign bus.IN_READY  = !full;
    assign bus.OUT_VALID = !empty;
    assign bus.OP        = empty ? 3'b000 : op_mem[rptr];
    assign bus.A         = empty ? '0 : a_mem[rptr];
    assign bus.B         = empty ? '0 : b_mem[rptr];
    assign bus.COUNT     = count;
    assign bus.ILLEGAL   = illegal;
endmodule

// File: tb/tb_alu_op_queue.sv
// Bench for alu_op_queue: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_alu_op_queue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_op_queue_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    alu_op_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ent_t;

    ent_t q[$];
    bit   m_ill;
    bit   m_live;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue updated with the values present at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ill  = 1'b0;
            m_live = 1'b1;
        end else if (bus.FLUSH) begin
            q.delete();
            m_ill = 1'b0;
        end else if (m_live) begin
            bit can_in;
            can_in = (q.size() < DEPTH);
            if (q.size() > 0 && bus.OUT_READY) void'(q.pop_front());
            if (bus.IN_VALID && can_in) begin
                if (bus.IN_OP == 3'b111) m_ill = 1'b1;
                else q.push_back('{op: bus.IN_OP, a: bus.IN_A, b: bus.IN_B});
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", 32'(bus.OUT_VALID), 32'(q.size() != 0));
            check("in_ready",  32'(bus.IN_READY),  32'(q.size() != DEPTH));
            check("count",     32'(bus.COUNT),     32'(q.size()));
            check("illegal",   32'(bus.ILLEGAL),   32'(m_ill));
            check("op", 32'(bus.OP), (q.size() != 0) ? 32'(q[0].op) : 32'd0);
            check("a",  32'(bus.A),  (q.size() != 0) ? 32'(q[0].a)  : 32'd0);
            check("b",  32'(bus.B),  (q.size() != 0) ? 32'(q[0].b)  : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy, input logic fl);
        bus.IN_VALID  = v;
        bus.IN_OP     = op;
        bus.IN_A      = a;
        bus.IN_B      = b;
        bus.OUT_READY = ordy;
        bus.FLUSH     = fl;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        m_live = 1'b0;
        m_ill  = 1'b0;
        rst    = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        check("t1_valid", 32'(bus.OUT_VALID), 0);
        check("t1_ready", 32'(bus.IN_READY), 1);
        check("t1_count", 32'(bus.COUNT), 0);
        check("t1_op",    32'(bus.OP), 0);
        check("t1_ab",    32'({bus.A, bus.B}), 0);
        check("t1_ill",   32'(bus.ILLEGAL), 0);

        // Single push held until consumed
        step();
        drive(1, 3'b001, 8'h05, 8'h03, 0, 0);
        step();
        drive(0, 3'b000, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        check("t2_valid", 32'(bus.OUT_VALID), 1);
        check("t2_op",    32'(bus.OP), 1);
        check("t2_a",     32'(bus.A), 32'h05);
        check("t2_b",     32'(bus.B), 32'h03);
        check("t2_count", 32'(bus.COUNT), 1);
        step();
        step();
        @(negedge clk);
        check("t2_hold_op", 32'(bus.OP), 1);
        check("t2_hold_a",  32'(bus.A), 32'h05);
        bus.OUT_READY = 1'b1;
        step();
        bus.OUT_READY = 1'b0;
        @(negedge clk);
        check("t2_popped", 32'(bus.OUT_VALID), 0);

        // Fill to DEPTH, stall, then drain with wrap
        step();
        drive(1, 3'd0, 8'h10, 8'h20, 0, 0);
        step();
        drive(1, 3'd2, 8'h11, 8'h21, 0, 0);
        step();
        drive(1, 3'd4, 8'h12, 8'h22, 0, 0);
        step();
        drive(1, 3'd5, 8'h13, 8'h23, 0, 0);
        step();
        drive(1, 3'd6, 8'h14, 8'h24, 0, 0);
        step();
        @(negedge clk);
        check("t3_full_ready", 32'(bus.IN_READY), 0);
        check("t3_full_count", 32'(bus.COUNT), 4);
        check("t3_head",       32'(bus.OP), 0);
        bus.OUT_READY = 1'b1;
        step();
        @(negedge clk);
        check("t3_pop1_op",    32'(bus.OP), 2);
        check("t3_pop1_count", 32'(bus.COUNT), 3);
        check("t3_pop1_ready", 32'(bus.IN_READY), 1);
        step();
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        check("t3_pop2_op",    32'(bus.OP), 4);
        check("t3_pop2_count", 32'(bus.COUNT), 3);
        step();
        step();
        @(negedge clk);
        check("t3_last_op", 32'(bus.OP), 6);
        check("t3_last_a",  32'(bus.A), 32'h14);
        step();
        @(negedge clk);
        check("t3_drained", 32'(bus.OUT_VALID), 0);

        // Steady streaming
        for (int i = 0; i < 20; i++) begin
            drive(1, 3'b010, 8'(i), 8'(i + 100), 1, 0);
            step();
            if (i == 10) begin
                @(negedge clk);
                check("t4_count", 32'(bus.COUNT), 1);
                check("t4_a",     32'(bus.A), 10);
            end
        end
        drive(0, 3'd0, 8'h00, 8'h00, 1, 0);
        step();
        step();
        bus.OUT_READY = 1'b0;

        // Illegal opcode dropped between two legal ops
        drive(1, 3'b011, 8'h01, 8'h02, 0, 0);
        step();
        drive(1, 3'b111, 8'hFF, 8'hFF, 0, 0);
        @(negedge clk);
        check("t5_ready_before_ill", 32'(bus.IN_READY), 1);
        step();
        drive(1, 3'b100, 8'h02, 8'h03, 0, 0);
        @(negedge clk);
        check("t5_ill",   32'(bus.ILLEGAL), 1);
        check("t5_count", 32'(bus.COUNT), 1);
        step();
        drive(1, 3'b001, 8'h07, 8'h08, 0, 0);
        @(negedge clk);
        check("t5_count2", 32'(bus.COUNT), 2);
        check("t5_head",   32'(bus.OP), 3);
        step();
        drive(1, 3'b101, 8'h33, 8'h44, 1, 1);
        @(negedge clk);
        check("t6_pre_count", 32'(bus.COUNT), 3);
        check("t6_pre_ill",   32'(bus.ILLEGAL), 1);

        // Flush with a concurrent push and pop
        step();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        check("t6_fl_count", 32'(bus.COUNT), 0);
        check("t6_fl_valid", 32'(bus.OUT_VALID), 0);
        check("t6_fl_ill",   32'(bus.ILLEGAL), 0);
        check("t6_fl_op",    32'(bus.OP), 0);

        // Reset mid-stream
        drive(1, 3'b010, 8'h55, 8'h66, 0, 0);
        step();
        drive(1, 3'b111, 8'hFF, 8'h00, 0, 0);
        step();
        drive(1, 3'b011, 8'h56, 8'h67, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        check("t6_rst_count", 32'(bus.COUNT), 0);
        check("t6_rst_valid", 32'(bus.OUT_VALID), 0);
        check("t6_rst_ill",   32'(bus.ILLEGAL), 0);
        check("t6_rst_ready", 32'(bus.IN_READY), 1);

        // Queue usable again after reset
        step();
        drive(1, 3'b110, 8'h77, 8'h88, 0, 0);
        step();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        check("t7_op", 32'(bus.OP), 6);
        check("t7_a",  32'(bus.A), 32'h77);
        check("t7_b",  32'(bus.B), 32'h88);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
